// File: rtl/cw_pkg.sv
// Shared chaffing-and-winnowing definitions: packet layout, packet struct and the MAC
// used by both the transmit and the winnow side.
package cw_pkg;

    localparam int MAC_MAXW    = 64;
    localparam int DEF_CTRSIZE = 16;
    localparam int DEF_TAGSIZE = 16;

    // Packet layout, LSB first: tag, counter, data bit.
    function automatic int pkt_tag_lsb();
        return 0;
    endfunction

    function automatic int pkt_ctr_lsb(input int tagsize);
        return tagsize;
    endfunction

    function automatic int pkt_data_pos(input int ctrsize, input int tagsize);
        return ctrsize + tagsize;
    endfunction

    typedef struct packed {
        logic                   data;
        logic [DEF_CTRSIZE-1:0] ctr;
        logic [DEF_TAGSIZE-1:0] tag;
    } cw_pkt_t;

    // mac = rotl1(ctr ^ key) ^ {w{b}}, evaluated in the low w bits of a wide word.
    function automatic logic [MAC_MAXW-1:0] mac(input logic [MAC_MAXW-1:0] ctr,
                                                input logic [MAC_MAXW-1:0] key,
                                                input logic                b,
                                                input int                  w);
        logic [MAC_MAXW-1:0] mask;
        logic [MAC_MAXW-1:0] x;
        logic [MAC_MAXW-1:0] r;
        mask = (w >= MAC_MAXW) ? '1 : ((MAC_MAXW'(1) << w) - MAC_MAXW'(1));
        x    = (ctr ^ key) & mask;
        r    = ((x << 1) | (x >> (w - 1))) & mask;
        return b ? (r ^ mask) : r;
    endfunction

endpackage

// File: rtl/cw_mac.sv
// Combinational expected-tag generator for one packet.
module cw_mac
    import cw_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] ctr,
    input  logic [W-1:0] key,
    input  logic         b,
    output logic [W-1:0] tag
);

    if (W > MAC_MAXW) begin : g_width_chk
        $error("cw_mac: W exceeds MAC_MAXW");
    end

    assign tag = W'(mac(MAC_MAXW'(ctr), MAC_MAXW'(key), b, W));

endmodule

// File: rtl/cw_winnow.sv
// Winnower: authenticates wheat/chaff packet pairs and assembles the message bit per counter.
module cw_winnow
    import cw_pkg::*;
#(
    parameter int CWBITS  = 32,
    parameter int CTRSIZE = 16,
    parameter int TAGSIZE = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TAGSIZE-1:0]         key,
    input  logic [CTRSIZE+TAGSIZE:0]   in_pkt,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [CWBITS-1:0]          msg,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic                       err_auth,
    output logic                       err_seq
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DONE    = 1'b1;

    localparam int DPOS = pkt_data_pos(CTRSIZE, TAGSIZE);
    localparam int CLSB = pkt_ctr_lsb(TAGSIZE);
    localparam int TLSB = pkt_tag_lsb();

    if (TAGSIZE != CTRSIZE) begin : g_size_chk
        $error("cw_winnow: TAGSIZE must equal CTRSIZE");
    end

    logic [0:0]         state;
    logic [CTRSIZE-1:0] ctr_exp;
    logic               half;
    logic               first_auth;
    logic               first_bit;

    logic               pkt_bit;
    logic [CTRSIZE-1:0] pkt_ctr;
    logic [TAGSIZE-1:0] pkt_tag;
    logic [TAGSIZE-1:0] exp_tag;
    logic               xfer;
    logic               auth;
    logic               one_auth;
    logic               pair_bit;
    logic               last;

    assign pkt_bit = in_pkt[DPOS];
    assign pkt_ctr = in_pkt[CLSB +: CTRSIZE];
    assign pkt_tag = in_pkt[TLSB +: TAGSIZE];

    cw_mac #(.W(TAGSIZE)) u_mac (
        .ctr (pkt_ctr),
        .key (key),
        .b   (pkt_bit),
        .tag (exp_tag)
    );

    // in_ready drops combinationally during reset so nothing is accepted on a reset edge.
    assign in_ready  = (state == COLLECT) && !rst;
    assign msg_valid = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign auth      = (pkt_tag == exp_tag);
    assign one_auth  = first_auth ^ auth;
    assign pair_bit  = first_auth ? first_bit : pkt_bit;
    assign last      = (ctr_exp == CTRSIZE'(CWBITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            msg        <= '0;
            err_auth   <= 1'b0;
            err_seq    <= 1'b0;
            ctr_exp    <= '0;
            half       <= 1'b0;
            first_auth <= 1'b0;
            first_bit  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        if (pkt_ctr != ctr_exp) begin
                            err_seq <= 1'b1;
                        end else if (!half) begin
                            half       <= 1'b1;
                            first_auth <= auth;
                            first_bit  <= pkt_bit;
                        end else begin
                            half    <= 1'b0;
                            ctr_exp <= ctr_exp + CTRSIZE'(1);
                            for (int i = 0; i < CWBITS; i++) begin
                                if (ctr_exp == CTRSIZE'(i)) msg[i] <= one_auth & pair_bit;
                            end
                            if (!one_auth) err_auth <= 1'b1;
                            if (last) state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (msg_ready) begin
                        state    <= COLLECT;
                        msg      <= '0;
                        err_auth <= 1'b0;
                        err_seq  <= 1'b0;
                        ctr_exp  <= '0;
                        half     <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cw_winnow.sv
// Scoreboard bench for cw_winnow: stimulus builds packet streams and expected messages
// from the MAC rules; a negedge monitor checks the DUT outputs against the queue.
module tb_cw_winnow;

    localparam int CWBITS  = 4;
    localparam int CTRSIZE = 16;
    localparam int TAGSIZE = 16;
    localparam logic [15:0] KEY = 16'hA5A5;

    logic                     clk;
    logic                     rst;
    logic [TAGSIZE-1:0]       key;
    logic [CTRSIZE+TAGSIZE:0] in_pkt;
    logic                     in_valid;
    logic                     in_ready;
    logic [CWBITS-1:0]        msg;
    logic                     msg_valid;
    logic                     msg_ready;
    logic                     err_auth;
    logic                     err_seq;

    cw_winnow #(.CWBITS(CWBITS), .CTRSIZE(CTRSIZE), .TAGSIZE(TAGSIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .err_auth  (err_auth),
        .err_seq   (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic       ea;
        logic       es;
        int         n;
    } exp_t;

    exp_t        sb[$];
    logic [32:0] pkts[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  cur_msg;
    logic        cur_ea;
    logic        cur_es;
    int          pair_idx;
    int          ready_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference MAC in plain arithmetic: rotate-left-by-one as *2 mod 2^16 plus carried MSB.
    function automatic logic [15:0] model_mac(input int ctr, input bit b);
        int x;
        int t;
        x = (ctr ^ int'(KEY)) & 32'hFFFF;
        t = ((x * 2) % 65536) + (x / 32768);
        if (b) t = 65535 - t;
        return t[15:0];
    endfunction

    function automatic bit authentic(input logic [32:0] p);
        return p[15:0] == model_mac(int'(p[31:16]), p[32]);
    endfunction

    task automatic begin_msg();
        cur_msg  = '0;
        cur_ea   = 1'b0;
        cur_es   = 1'b0;
        pair_idx = 0;
        pkts.delete();
    endtask

    task automatic add_bad(input int c);
        pkts.push_back({1'($urandom_range(0, 1)), 16'(c), 16'($urandom)});
        cur_es = 1'b1;
    endtask

    function automatic int bad_ctr();
        int c;
        c = $urandom_range(0, 65535);
        if (c == pair_idx) c = (c + 1) % 65536;
        return c;
    endfunction

    // inj: 0 none, 1 stray packet before the pair, 2 stray packet between its halves.
    task automatic add_pair_raw(input logic [32:0] p0, input logic [32:0] p1, input int inj);
        bit a0;
        bit a1;
        a0 = authentic(p0);
        a1 = authentic(p1);
        if (inj == 1) add_bad(bad_ctr());
        pkts.push_back(p0);
        if (inj == 2) add_bad(bad_ctr());
        pkts.push_back(p1);
        if (a0 != a1) cur_msg[pair_idx] = a0 ? p0[32] : p1[32];
        else          cur_ea = 1'b1;
        pair_idx++;
    endtask

    // mode: 0 wheat+chaff, 1 both authentic, 2 neither authentic.
    task automatic add_pair(input int mode, input bit b, input bit swap, input int inj);
        logic [32:0] w;
        logic [32:0] c;
        logic [15:0] nz;
        nz = 16'($urandom_range(1, 65534));
        w = {b, 16'(pair_idx), model_mac(pair_idx, b)};
        case (mode)
            1:       c = {~b, 16'(pair_idx), model_mac(pair_idx, ~b)};
            2: begin
                w = {b, 16'(pair_idx), model_mac(pair_idx, b) ^ nz};
                c = {~b, 16'(pair_idx), model_mac(pair_idx, ~b) ^ nz};
            end
            default: c = {~b, 16'(pair_idx), model_mac(pair_idx, b)};
        endcase
        if (swap) add_pair_raw(c, w, inj);
        else      add_pair_raw(w, c, inj);
    endtask

    task automatic push_exp();
        exp_t e;
        e.m  = cur_msg;
        e.ea = cur_ea;
        e.es = cur_es;
        e.n  = pkts.size();
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [32:0] p, output int waits);
        logic r;
        in_valid = 1'b1;
        in_pkt   = p;
        waits    = 0;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits > 200) begin
                chk("send_timeout", 32'(waits), 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input bit gaps);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(pkts[i], w);
        end
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Consumer: mode 0 random, 1 holds msg_ready low for 10 DONE cycles, 2 never ready.
    initial begin
        int done_cyc;
        done_cyc  = 0;
        msg_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    if (msg_valid) begin
                        done_cyc++;
                        msg_ready = (done_cyc > 10);
                    end else begin
                        done_cyc  = 0;
                        msg_ready = 1'b0;
                    end
                end
                2:       msg_ready = 1'b0;
                default: msg_ready = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    // Monitor
    int         cnt = 0;
    bit         armed = 0;
    bit         in_done = 0;
    bit         clr_chk = 0;
    bit         rst_prev = 0;
    logic [3:0] held_msg;
    logic       held_ea;
    logic       held_es;

    always @(negedge clk) begin
        exp_t d;
        if (rst) begin
            chk("in_ready_during_reset", 32'(in_ready), 0);
            if (rst_prev) begin
                chk("reset_msg_valid", 32'(msg_valid), 0);
                chk("reset_msg", 32'(msg), 0);
                chk("reset_err_auth", 32'(err_auth), 0);
                chk("reset_err_seq", 32'(err_seq), 0);
            end
            if (in_done && sb.size() > 0) d = sb.pop_front();
            in_done = 0;
            cnt     = 0;
            armed   = 0;
            clr_chk = 0;
        end else begin
            if (clr_chk) begin
                chk("clear_msg", 32'(msg), 0);
                chk("clear_err_auth", 32'(err_auth), 0);
                chk("clear_err_seq", 32'(err_seq), 0);
                chk("clear_in_ready", 32'(in_ready), 1);
                clr_chk = 0;
            end
            if (armed) begin
                chk("msg_valid_latency", 32'(msg_valid), 1);
                if (sb.size() > 0) begin
                    chk("msg", 32'(msg), 32'(sb[0].m));
                    chk("err_auth", 32'(err_auth), 32'(sb[0].ea));
                    chk("err_seq", 32'(err_seq), 32'(sb[0].es));
                end else begin
                    chk("scoreboard_empty", 32'(sb.size()), 1);
                end
                held_msg = msg;
                held_ea  = err_auth;
                held_es  = err_seq;
                in_done  = 1;
                armed    = 0;
            end else if (in_done) begin
                chk("done_msg_valid", 32'(msg_valid), 1);
                chk("done_in_ready", 32'(in_ready), 0);
                chk("done_msg_stable", 32'(msg), 32'(held_msg));
                chk("done_err_stable", {30'd0, err_auth, err_seq}, {30'd0, held_ea, held_es});
            end else begin
                chk("no_early_msg_valid", 32'(msg_valid), 0);
            end
            if (in_done && msg_valid && msg_ready) begin
                if (sb.size() > 0) d = sb.pop_front();
                in_done = 0;
                cnt     = 0;
                clr_chk = 1;
            end else if (!in_done && in_valid && in_ready) begin
                cnt++;
                if (sb.size() > 0 && cnt == sb[0].n) armed = 1;
            end
        end
        rst_prev = rst;
    end

    initial begin
        int w;
        int t;
        rst      = 1'b1;
        key      = KEY;
        in_valid = 1'b0;
        in_pkt   = '0;
        idle(3);
        rst = 1'b0;

        // Literal counter-0 pair, then message 1010 (msg[i] = bit of counter i) with alternating order.
        begin_msg();
        add_pair_raw({1'b1, 16'd0, 16'hB4B4}, {1'b0, 16'd0, 16'h1234}, 0);
        add_pair(0, 1'b0, 1'b1, 0);
        add_pair(0, 1'b1, 1'b0, 0);
        add_pair(0, 1'b0, 1'b1, 0);
        push_exp();
        send_n(pkts.size(), 1'b0);
        wait_drained();

        // Counter 2 carries two authentic packets; consumer stalls 10 cycles in DONE.
        ready_mode = 1;
        begin_msg();
        add_pair(0, 1'b1, 1'b0, 0);
        add_pair(0, 1'b1, 1'b1, 0);
        add_pair(1, 1'b1, 1'b0, 0);
        add_pair(0, 1'b1, 1'b1, 0);
        push_exp();
        send_n(pkts.size(), 1'b0);
        wait_drained();
        ready_mode = 0;

        // Counter 3 arrives while counter 1 is expected.
        begin_msg();
        add_pair(0, 1'b1, 1'b0, 0);
        add_bad(3);
        add_pair(0, 1'b1, 1'b1, 0);
        add_pair(0, 1'b0, 1'b0, 0);
        add_pair(0, 1'b1, 1'b1, 0);
        push_exp();
        send_n(pkts.size(), 1'b1);
        wait_drained();

        // Reset after 5 transfers, then a fresh message starting on the first edge after reset.
        begin_msg();
        for (int i = 0; i < 3; i++) add_pair(0, 1'($urandom_range(0, 1)), 1'b0, 0);
        send_n(5, 1'b0);
        pulse_rst();
        begin_msg();
        for (int i = 0; i < CWBITS; i++) add_pair(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        push_exp();
        send(pkts[0], w);
        chk("first_xfer_after_reset_waits", 32'(w), 0);
        for (int i = 1; i < pkts.size(); i++) send(pkts[i], w);
        wait_drained();

        // Reset while holding a completed message in DONE.
        ready_mode = 2;
        begin_msg();
        for (int i = 0; i < CWBITS; i++) add_pair(0, 1'($urandom_range(0, 1)), 1'b0, 0);
        push_exp();
        send_n(pkts.size(), 1'b0);
        t = 0;
        while (!msg_valid && t < 50) begin
            idle(1);
            t++;
        end
        idle(2);
        pulse_rst();
        chk("reset_in_done_drops_msg", 32'(sb.size()), 0);
        ready_mode = 0;

        // Randomized messages.
        for (int m = 0; m < 40; m++) begin
            begin_msg();
            for (int i = 0; i < CWBITS; i++) begin
                int r;
                int inj;
                r   = $urandom_range(0, 9);
                inj = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
                add_pair((r < 7) ? 0 : (r < 9 ? 1 : 2), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), inj);
            end
            push_exp();
            send_n(pkts.size(), 1'b1);
        end
        wait_drained();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
